// File: rtl/dcache_miss_handler.sv
// rtl/dcache_miss_handler.sv - direct-mapped write-through dcache controller with refill/write-through status pulses
// Optional DCACHE_STATS_EN adds saturating hit/miss/store counters.
module dcache_miss_handler #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              data_missed1,
  output logic              data_busy,
  output logic              data_finished1,
  output logic              write_busy,
  output logic              write_finished,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_writes
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOOKUP     = 3'd1;
  localparam logic [2:0] MISS_REQ   = 3'd2;
  localparam logic [2:0] MISS_WAIT  = 3'd3;
  localparam logic [2:0] WRITE_REQ  = 3'd4;
  localparam logic [2:0] WRITE_WAIT = 3'd5;
  localparam logic [2:0] FINISH     = 3'd6;

  logic [2:0]        state;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              flushed;
  logic              fin_refill;

  logic [LINES-1:0]  line_valid;
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [DATA_W-1:0] line_data [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              cancel;

  assign idx    = lat_addr[IDX_W+1:2];
  assign tag    = lat_addr[ADDR_W-1:IDX_W+2];
  assign hit    = line_valid[idx] && (line_tag[idx] == tag);
  // A flush seen at any point of the memory phase, including the response cycle, silences resp_valid.
  assign cancel = flushed || flush;

  assign req_ready     = (state == IDLE);
  assign mem_req_valid = (state == MISS_REQ) || (state == WRITE_REQ);
  assign mem_req_write = (state == WRITE_REQ);
  assign mem_req_addr  = mem_req_valid ? lat_addr : '0;
  assign mem_req_wdata = mem_req_write ? lat_wdata : '0;
  assign data_busy     = (state == MISS_REQ) || (state == MISS_WAIT) || (state == FINISH && fin_refill);
  assign write_busy    = (state == WRITE_REQ) || (state == WRITE_WAIT) || (state == FINISH && !fin_refill);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      lat_write      <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      flushed        <= 1'b0;
      fin_refill     <= 1'b0;
      line_valid     <= '0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      data_missed1   <= 1'b0;
      data_finished1 <= 1'b0;
      write_finished <= 1'b0;
    end else begin
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      data_missed1   <= 1'b0;
      data_finished1 <= 1'b0;
      write_finished <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            flushed   <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (flush) begin
            state <= IDLE;
          end else if (lat_write) begin
            if (hit) line_data[idx] <= lat_wdata;
            fin_refill <= 1'b0;
            state      <= WRITE_REQ;
          end else if (hit) begin
            resp_valid <= 1'b1;
            resp_data  <= line_data[idx];
            state      <= IDLE;
          end else begin
            data_missed1 <= 1'b1;
            fin_refill   <= 1'b1;
            state        <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (flush) flushed <= 1'b1;
          if (mem_req_ready) state <= MISS_WAIT;
        end
        MISS_WAIT: begin
          if (flush) flushed <= 1'b1;
          if (mem_resp_valid) begin
            line_valid[idx] <= 1'b1;
            line_tag[idx]   <= tag;
            line_data[idx]  <= mem_resp_data;
            resp_valid      <= !cancel;
            resp_data       <= cancel ? '0 : mem_resp_data;
            data_finished1  <= 1'b1;
            state           <= FINISH;
          end
        end
        WRITE_REQ: begin
          if (flush) flushed <= 1'b1;
          if (mem_req_ready) state <= WRITE_WAIT;
        end
        WRITE_WAIT: begin
          if (flush) flushed <= 1'b1;
          if (mem_resp_valid) begin
            resp_valid     <= !cancel;
            write_finished <= 1'b1;
            state          <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_writes <= '0;
    end else if (state == LOOKUP) begin
      if (hit && stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
      if (!lat_write && !hit && stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
      if (lat_write && stat_writes != 32'hFFFF_FFFF) stat_writes <= stat_writes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_miss_handler.sv
// tb/tb_dcache_miss_handler.sv - randomized bench for dcache_miss_handler against a line/memory reference model
module tb_dcache_miss_handler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        data_missed1;
  logic        data_busy;
  logic        data_finished1;
  logic        write_busy;
  logic        write_finished;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_write;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: each line remembers the full word address it holds; memory is a sparse word store.
  logic        m_vld  [16];
  logic [31:0] m_addr [16];
  logic [31:0] m_data [16];
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  dcache_miss_handler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .data_missed1(data_missed1), .data_busy(data_busy), .data_finished1(data_finished1),
    .write_busy(write_busy), .write_finished(write_finished),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flush_at: 0 none, 1 during LOOKUP, 2 on first memory-wait cycle
  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ready_dly, input int resp_dly, input int flush_at);
    int          idx;
    logic        exp_hit;
    logic [31:0] rdata;
    idx     = int'(addr[5:2]);
    exp_hit = m_vld[idx] && (m_addr[idx] == addr);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    if (flush_at == 1) flush = 1'b1;
    check("lookup_req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    if (flush_at == 1) begin
      flush = 1'b0;
      check("flushed_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("flushed_missed", {31'd0, data_missed1}, 32'd0);
      check("flushed_mem_req", {31'd0, mem_req_valid}, 32'd0);
      check("flushed_ready", {31'd0, req_ready}, 32'd1);
      return;
    end
    if (!wr && exp_hit) begin
      check("hit_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hit_resp_data", resp_data, m_data[idx]);
      check("hit_ready", {31'd0, req_ready}, 32'd1);
      check("hit_no_mem", {31'd0, mem_req_valid}, 32'd0);
      check("hit_missed", {31'd0, data_missed1}, 32'd0);
      return;
    end
    check("missed_pulse", {31'd0, data_missed1}, {31'd0, !wr});
    check("resp_early", {31'd0, resp_valid}, 32'd0);
    for (int i = 0; i <= ready_dly; i++) begin
      if (i > 0) check("missed_width", {31'd0, data_missed1}, 32'd0);
      check("mreq_valid", {31'd0, mem_req_valid}, 32'd1);
      check("mreq_write", {31'd0, mem_req_write}, {31'd0, wr});
      check("mreq_addr", mem_req_addr, addr);
      if (wr) check("mreq_wdata", mem_req_wdata, wdata);
      check("req_data_busy", {31'd0, data_busy}, {31'd0, !wr});
      check("req_write_busy", {31'd0, write_busy}, {31'd0, wr});
      if (i == ready_dly) mem_req_ready = 1'b1;
      tick();
    end
    mem_req_ready = 1'b0;
    if (flush_at == 2) flush = 1'b1;
    check("wait_mreq_valid", {31'd0, mem_req_valid}, 32'd0);
    for (int i = 0; i < resp_dly; i++) begin
      tick();
      flush = 1'b0;
      check("wait_data_busy", {31'd0, data_busy}, {31'd0, !wr});
      check("wait_write_busy", {31'd0, write_busy}, {31'd0, wr});
      check("wait_resp", {31'd0, resp_valid}, 32'd0);
    end
    rdata = mem_read(addr);
    mem_resp_valid = 1'b1;
    mem_resp_data  = wr ? 32'h0 : rdata;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    flush = 1'b0;
    check("fin_resp_valid", {31'd0, resp_valid}, {31'd0, flush_at == 0});
    if (flush_at == 0) check("fin_resp_data", resp_data, wr ? 32'h0 : rdata);
    check("fin_data_finished", {31'd0, data_finished1}, {31'd0, !wr});
    check("fin_write_finished", {31'd0, write_finished}, {31'd0, wr});
    check("fin_data_busy", {31'd0, data_busy}, {31'd0, !wr});
    check("fin_write_busy", {31'd0, write_busy}, {31'd0, wr});
    check("fin_missed", {31'd0, data_missed1}, 32'd0);
    tick();
    check("post_ready", {31'd0, req_ready}, 32'd1);
    check("post_busy", {30'd0, data_busy, write_busy}, 32'd0);
    check("post_pulses", {29'd0, resp_valid, data_finished1, write_finished}, 32'd0);
    if (wr) begin
      mem[addr] = wdata;
      if (exp_hit) m_data[idx] = wdata;
    end else begin
      m_vld[idx] = 1'b1; m_addr[idx] = addr; m_data[idx] = rdata;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
    mem[32'h40] = 32'hDEAD_BEEF;
    repeat (3) tick();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outputs", {25'd0, resp_valid, data_missed1, data_busy, data_finished1,
                          write_busy, write_finished, mem_req_valid}, 32'd0);
    reset = 1'b1;
    tick();

    run_req(1'b0, 32'h40, 32'h0, 0, 2, 0);
    run_req(1'b0, 32'h40, 32'h0, 0, 0, 0);
    run_req(1'b1, 32'h40, 32'h1234_5678, 1, 1, 0);
    run_req(1'b0, 32'h40, 32'h0, 0, 0, 0);
    run_req(1'b0, 32'h80, 32'h0, 0, 1, 0);
    run_req(1'b0, 32'h40, 32'h0, 0, 1, 0);
    run_req(1'b0, 32'hC4, 32'h0, 0, 2, 2);
    run_req(1'b0, 32'hC4, 32'h0, 0, 0, 0);
    run_req(1'b0, 32'h100, 32'h0, 5, 1, 0);
    run_req(1'b1, 32'h100, 32'hA5A5_0001, 0, 0, 1);
    run_req(1'b0, 32'h100, 32'h0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int          f;
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      f = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_req(1'($urandom_range(0, 2) == 0), a, $urandom, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), f);
    end

    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1C0; req_wdata = '0;
    tick();
    req_valid = 1'b0;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_busy", {30'd0, data_busy, mem_req_valid}, 32'd0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_BAD0;
    tick();
    mem_resp_valid = 1'b0;
    check("late_resp_ignored", {29'd0, resp_valid, data_finished1, req_ready}, 32'd1);
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
    run_req(1'b0, 32'h40, 32'h0, 0, 0, 0);
    run_req(1'b0, 32'h40, 32'h0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
